// File: rtl/vseq_pkg.sv
// Shared types for the vector op sequencer: ALU op codes, FSM states, sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vseq_pkg;

  localparam int NUM_ELEMS_DEF = 8;
  localparam int IDX_W_DEF     = $clog2(NUM_ELEMS_DEF);

  typedef enum logic [2:0] {
    ALU_ADD     = 3'b000,
    ALU_SUB     = 3'b001,
    ALU_MOV     = 3'b010,
    ALU_MUL     = 3'b011,
    ALU_DIV     = 3'b100,
    ALU_CMP     = 3'b101,
    ALU_ILLEGAL = 3'b110,
    ALU_MEM     = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_MC_START = 3'd2,
    S_MC_WAIT  = 3'd3,
    S_DONE     = 3'd4
  } vseq_state_e;

  // MUL and DIV go through the multi-cycle unit; everything else is single-cycle.
  function automatic logic is_mc_op(input logic [2:0] op);
    return (alu_op_e'(op) == ALU_MUL) || (alu_op_e'(op) == ALU_DIV);
  endfunction

endpackage

// File: rtl/vseq_elem_counter.sv
// Element index counter: holds the active length and steps the beat index.
// Latency: idx updates on the clock after clear/inc; last is combinational.
// Backpressure: none; inc is ignored once the last element is reached.
module vseq_elem_counter #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [IDX_W:0]   load_len,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W:0] len;

  // Length register and saturating-at-last index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      len <= '0;
      idx <= '0;
    end else begin
      if (load) begin
        len <= load_len;
      end
      if (clear) begin
        idx <= '0;
      end else if (inc && !last) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // A zero length wraps len-1 to all ones, so last never fires for it.
  assign last = ({1'b0, idx} == (len - (IDX_W + 1)'(1)));

endmodule

// File: rtl/vector_op_sequencer.sv
// Steps one decoded vector instruction through its elements; optional MC watchdog via VSEQ_MC_TIMEOUT_EN.
// Latency: single-cycle op beats at cycles 1..N after accept, done at N+1; MUL/DIV 1 start + wait per element.
// Backpressure: issue_ready only in IDLE (stall otherwise); MC elements wait on mc_done.
module vector_op_sequencer
  import vseq_pkg::*;
#(
  parameter int NUM_ELEMS  = NUM_ELEMS_DEF,
  parameter int IDX_W      = IDX_W_DEF
`ifdef VSEQ_MC_TIMEOUT_EN
  , parameter int MC_TIMEOUT = 64
`endif
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             mem_to_reg,
  input  logic [IDX_W:0]   vlen,
  output logic             elem_valid,
  output logic [IDX_W-1:0] elem_idx,
  output logic [2:0]       elem_alu_ctrl,
  output logic             elem_reg_we,
  output logic             elem_mem_we,
  output logic             elem_mem_to_reg,
  output logic             mc_start,
  input  logic             mc_done,
  output logic             stall,
  output logic             done,
  output logic             err
);

  localparam logic [IDX_W:0] MAX_LEN = (IDX_W + 1)'(NUM_ELEMS);

  vseq_state_e      state, state_nxt;
  logic [2:0]       alu_q;
  logic             reg_we_q, mem_we_q, m2r_q;
  logic [IDX_W:0]   eff_len;
  logic             accept;
  logic             beat;
  logic             last;
  logic             timeout;
  logic [IDX_W-1:0] idx;

  assign eff_len = (vlen > MAX_LEN) ? MAX_LEN : vlen;
  assign accept  = (state == S_IDLE) && issue_valid;

  vseq_elem_counter #(.IDX_W(IDX_W)) u_cnt (
    .clk      (Clock),
    .reset    (reset),
    .load     (accept),
    .load_len (eff_len),
    .clear    (accept),
    .inc      (beat),
    .idx      (idx),
    .last     (last)
  );

`ifdef VSEQ_MC_TIMEOUT_EN
  localparam int TO_W = $clog2(MC_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  // Watchdog counts MC_WAIT cycles without mc_done; it is zero on every entry.
  always_ff @(posedge Clock) begin
    if (reset || (state != S_MC_WAIT)) begin
      to_cnt <= '0;
    end else if (!mc_done) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout = (state == S_MC_WAIT) && !mc_done && (to_cnt == TO_W'(MC_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // Instruction fields are captured once at accept and held until the next one.
  always_ff @(posedge Clock) begin
    if (reset) begin
      alu_q    <= '0;
      reg_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      m2r_q    <= 1'b0;
    end else if (accept) begin
      alu_q    <= alu_ctrl;
      reg_we_q <= reg_write;
      mem_we_q <= mem_write;
      m2r_q    <= mem_to_reg;
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (issue_valid) begin
          if ((eff_len == '0) || (alu_op_e'(alu_ctrl) == ALU_ILLEGAL)) begin
            state_nxt = S_DONE;
          end else if (is_mc_op(alu_ctrl)) begin
            state_nxt = S_MC_START;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN:      if (last) state_nxt = S_DONE;
      S_MC_START: state_nxt = S_MC_WAIT;
      S_MC_WAIT: begin
        if (mc_done) begin
          state_nxt = last ? S_DONE : S_MC_START;
        end else if (timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode from state; everything is forced low while reset is held.
  always_comb begin
    beat            = 1'b0;
    issue_ready     = 1'b0;
    stall           = 1'b0;
    elem_valid      = 1'b0;
    elem_idx        = '0;
    elem_alu_ctrl   = '0;
    elem_reg_we     = 1'b0;
    elem_mem_we     = 1'b0;
    elem_mem_to_reg = 1'b0;
    mc_start        = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    if (!reset) begin
      beat            = (state == S_RUN) || ((state == S_MC_WAIT) && mc_done);
      issue_ready     = (state == S_IDLE);
      stall           = (state != S_IDLE);
      elem_valid      = beat;
      elem_idx        = idx;
      elem_alu_ctrl   = alu_q;
      elem_reg_we     = reg_we_q & beat;
      elem_mem_we     = mem_we_q & beat;
      elem_mem_to_reg = m2r_q;
      mc_start        = (state == S_MC_START);
      done            = (state == S_DONE);
      err             = timeout;
    end
  end

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Bench for vector_op_sequencer: directed table, randomized instructions vs. model, reset and MC-stall sequences.
// Latency: drives at negedge, samples 1ns after negedge.
// Backpressure: mc_done is returned a programmable number of cycles after each mc_start.
module tb_vector_op_sequencer;

  logic       Clock = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic       issue_ready;
  logic [2:0] alu_ctrl;
  logic       reg_write, mem_write, mem_to_reg;
  logic [3:0] vlen;
  logic       elem_valid;
  logic [2:0] elem_idx;
  logic [2:0] elem_alu_ctrl;
  logic       elem_reg_we, elem_mem_we, elem_mem_to_reg;
  logic       mc_start;
  logic       mc_done;
  logic       stall, done, err;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

`ifdef VSEQ_MC_TIMEOUT_EN
  vector_op_sequencer #(.NUM_ELEMS(8), .IDX_W(3), .MC_TIMEOUT(8)) dut (
`else
  vector_op_sequencer #(.NUM_ELEMS(8), .IDX_W(3)) dut (
`endif
    .Clock(Clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .alu_ctrl(alu_ctrl), .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .vlen(vlen), .elem_valid(elem_valid), .elem_idx(elem_idx), .elem_alu_ctrl(elem_alu_ctrl),
    .elem_reg_we(elem_reg_we), .elem_mem_we(elem_mem_we), .elem_mem_to_reg(elem_mem_to_reg),
    .mc_start(mc_start), .mc_done(mc_done), .stall(stall), .done(done), .err(err)
  );

  wire [16:0] all_outs = {issue_ready, elem_valid, elem_idx, elem_alu_ctrl, elem_reg_we,
                          elem_mem_we, elem_mem_to_reg, mc_start, stall, done, err};

  typedef struct {
    string nm;
    int op, rw, mw, m2r, vl, d;
    int exp_beats, exp_done, exp_mcs;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Instruction-level reference: element count after clamp, then cost per element.
  task automatic model(input int op, input int vl, input int d,
                       output int beats, output int done_c, output int mcs);
    int eff;
    bit mc;
    eff    = (vl > 8) ? 8 : vl;
    beats  = (op == 6) ? 0 : eff;
    mc     = (op == 3) || (op == 4);
    mcs    = mc ? beats : 0;
    done_c = 1 + beats * (mc ? d + 1 : 1);
  endtask

  task automatic run_instr(input vec_t v);
    int beats, mcs, done_c, bad, cd;
    bit mc;
    beats = 0; mcs = 0; done_c = -1; bad = 0; cd = 0;
    mc = (v.op == 3) || (v.op == 4);
    @(negedge Clock);
    issue_valid = 1'b1;
    alu_ctrl    = 3'(v.op);
    reg_write   = v.rw[0];
    mem_write   = v.mw[0];
    mem_to_reg  = v.m2r[0];
    vlen        = 4'(v.vl);
    #1;
    if (!issue_ready) bad++;
    for (int c = 1; c <= 400 && done_c < 0; c++) begin
      @(negedge Clock);
      issue_valid = 1'b0;
      // Scramble the issue fields: only the accepted values may reach the datapath.
      alu_ctrl   = 3'($urandom);
      reg_write  = 1'($urandom);
      mem_write  = 1'($urandom);
      mem_to_reg = 1'($urandom);
      vlen       = 4'($urandom);
      if (cd > 0) begin
        cd--;
        mc_done = (cd == 0);
      end else begin
        mc_done = mc ? 1'b0 : 1'($urandom);
      end
      #1;
      if (elem_valid) begin
        if (int'(elem_idx) != beats) bad++;
        if (elem_reg_we != v.rw[0]) bad++;
        if (elem_mem_we != v.mw[0]) bad++;
        if (elem_mem_to_reg != v.m2r[0]) bad++;
        if (int'(elem_alu_ctrl) != v.op) bad++;
        if (mc && !mc_done) bad++;
        beats++;
      end
      if (mc_start) begin
        mcs++;
        cd = v.d;
      end
      if (err) bad++;
      if (done) begin
        done_c = c;
        if (issue_ready || !stall) bad++;
      end else if (!stall || issue_ready) begin
        bad++;
      end
    end
    mc_done = 1'b0;
    check({v.nm, ".beats"}, beats, v.exp_beats);
    check({v.nm, ".done_cycle"}, done_c, v.exp_done);
    check({v.nm, ".mc_starts"}, mcs, v.exp_mcs);
    check({v.nm, ".beat_fields"}, bad, 0);
    @(negedge Clock);
    #1;
    check({v.nm, ".ready_after"}, {31'd0, issue_ready, done}, 2);
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   bad, err_c, done_c, mcs;

  initial begin
    // name, op, rw, mw, m2r, vlen, mc delay, beats, done cycle, mc starts
    tbl[0] = '{"add4",    0, 1, 0, 0,  4, 1, 4,  5, 0};
    tbl[1] = '{"div2",    4, 1, 0, 0,  2, 3, 2,  9, 2};
    tbl[2] = '{"str3",    7, 0, 1, 0,  3, 1, 3,  4, 0};
    tbl[3] = '{"vlen0",   0, 1, 0, 0,  0, 1, 0,  1, 0};
    tbl[4] = '{"vlen12",  1, 1, 0, 1, 12, 1, 8,  9, 0};
    tbl[5] = '{"illegal", 6, 1, 1, 0,  5, 1, 0,  1, 0};
    tbl[6] = '{"mul1",    3, 1, 0, 0,  1, 1, 1,  3, 1};
    tbl[7] = '{"ldr8",    7, 1, 0, 1,  8, 1, 8,  9, 0};

    reset = 1'b1; issue_valid = 1'b0; alu_ctrl = 3'd0; reg_write = 1'b0;
    mem_write = 1'b0; mem_to_reg = 1'b0; vlen = 4'd0; mc_done = 1'b0;

    // Reset state.
    repeat (3) @(negedge Clock);
    issue_valid = 1'b1; vlen = 4'd3;
    #1 check("reset.outs", int'(all_outs), 0);
    @(negedge Clock);
    reset = 1'b0; issue_valid = 1'b0;
    @(negedge Clock);
    #1 check("post_reset.ready", {31'd0, issue_ready}, 1);
    check("post_reset.fields", {26'd0, elem_idx, elem_alu_ctrl, stall, done, err}, 0);

    foreach (tbl[i]) run_instr(tbl[i]);

    // Randomized instructions against the model.
    for (int i = 0; i < 20; i++) begin
      rv.nm  = $sformatf("rand%0d", i);
      rv.op  = int'($urandom_range(0, 7));
      rv.rw  = int'($urandom_range(0, 1));
      rv.mw  = int'($urandom_range(0, 1));
      rv.m2r = int'($urandom_range(0, 1));
      rv.vl  = int'($urandom_range(0, 15));
      rv.d   = int'($urandom_range(1, 4));
      model(rv.op, rv.vl, rv.d, rv.exp_beats, rv.exp_done, rv.exp_mcs);
      run_instr(rv);
    end

    // Reset in the middle of a RUN, at element 2.
    @(negedge Clock);
    issue_valid = 1'b1; alu_ctrl = 3'd0; reg_write = 1'b1; vlen = 4'd6;
    bad = 1;
    for (int c = 0; c < 20 && bad != 0; c++) begin
      @(negedge Clock);
      issue_valid = 1'b0;
      #1;
      if (elem_valid && elem_idx == 3'd2) bad = 0;
    end
    check("midrun.reached_idx2", bad, 0);
    reset = 1'b1;
    #1 check("midrun.reset_outs", int'(all_outs), 0);
    @(negedge Clock);
    #1 check("midrun.next_outs", int'(all_outs), 0);
    reset = 1'b0;
    @(negedge Clock);
    #1 check("midrun.recover", {29'd0, issue_ready, stall, done}, 4);
    check("midrun.idx", int'(elem_idx), 0);
    rv = '{"after_reset_add", 0, 1, 0, 0, 3, 1, 3, 4, 0};
    run_instr(rv);

    // MUL whose unit never answers.
    @(negedge Clock);
    issue_valid = 1'b1; alu_ctrl = 3'd3; reg_write = 1'b1; vlen = 4'd2; mc_done = 1'b0;
    bad = 0; err_c = -1; done_c = -1; mcs = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge Clock);
      issue_valid = 1'b0;
      #1;
      if (mc_start) mcs++;
      if (elem_valid) bad++;
      if (err && err_c < 0) err_c = c;
      if (done && done_c < 0) done_c = c;
`ifndef VSEQ_MC_TIMEOUT_EN
      if (!stall) bad++;
`endif
    end
    check("mcstall.mc_starts", mcs, 1);
    check("mcstall.no_beats", bad, 0);
`ifdef VSEQ_MC_TIMEOUT_EN
    check("mcstall.err_cycle", err_c, 9);
    check("mcstall.done_cycle", done_c, 10);
`else
    check("mcstall.err_cycle", err_c, -1);
    check("mcstall.done_cycle", done_c, -1);
    reset = 1'b1;
    @(negedge Clock);
    reset = 1'b0;
`endif
    @(negedge Clock);
    #1 check("mcstall.idle_after", {30'd0, issue_ready, stall}, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/vector_op_sequencer.md
Name: vector_op_sequencer

Overview:
- Multi-cycle sequencer between the control unit and the vector datapath.
- Accepts one decoded instruction per handshake: ALUControl, RegWrite, MemWrite, MemToReg and a vector length.
- Steps the datapath through each element, one beat at a time.
- Single-cycle ops issue one element per cycle. MUL/DIV elements are handed to the multi-cycle unit with a start/done handshake. Upstream fetch stalls until the instruction retires.

Parameters:
- NUM_ELEMS, 8, maximum vector elements per instruction.
- IDX_W, 3, element index width; must equal clog2(NUM_ELEMS).
- MC_TIMEOUT, 64, watchdog limit in cycles for the multi-cycle unit; used only with the optional feature.

Ports:
- Clock, in, 1, system clock, rising edge.
- reset, in, 1, synchronous, active-high.
- issue_valid, in, 1, decoded instruction present.
- issue_ready, out, 1, sequencer can accept.
- alu_ctrl, in, 3, ALUControl: 000 ADD, 001 SUB, 010 MOV, 011 MUL, 100 DIV, 101 CMP, 111 LDR/STR address; 110 illegal.
- reg_write, in, 1, RegWrite from control unit.
- mem_write, in, 1, MemWrite from control unit.
- mem_to_reg, in, 1, MemToReg from control unit.
- vlen, in, IDX_W+1, active element count.
- elem_valid, out, 1, element beat strobe to datapath.
- elem_idx, out, IDX_W, element index of current beat.
- elem_alu_ctrl, out, 3, latched alu_ctrl.
- elem_reg_we, out, 1, reg_write AND elem_valid.
- elem_mem_we, out, 1, mem_write AND elem_valid.
- elem_mem_to_reg, out, 1, latched mem_to_reg.
- mc_start, out, 1, one-cycle start pulse to the MUL/DIV unit.
- mc_done, in, 1, MUL/DIV result ready.
- stall, out, 1, high whenever state is not IDLE.
- done, out, 1, one-cycle retire pulse.
- err, out, 1, one-cycle error pulse; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset: synchronous, active-high. While reset is high, every output is 0, including issue_ready; elem_idx = 0. After the reset edge, state = IDLE and the latched fields are 0. Reset mid-operation aborts immediately: no done pulse, and in-flight mc work is discarded.
- Clock and reset are the only timing controls: single clock domain, reset synchronous and active-high, clock port named Clock and reset port named reset.
- States: IDLE, RUN, MC_START, MC_WAIT, DONE.
- IDLE:
  - issue_ready = 1.
  - On issue_valid, latch alu_ctrl, reg_write, mem_write, mem_to_reg and eff_len = min(vlen, NUM_ELEMS); clear the index.
  - Next state: DONE if eff_len == 0 or alu_ctrl == 110 (no beats). Otherwise MC_START if alu_ctrl is MUL or DIV. Otherwise RUN.
- RUN (ADD/SUB/MOV/CMP/LDR/STR):
  - elem_valid = 1 every cycle, elem_idx = index.
  - The index increments after each beat.
  - After the beat with index == eff_len-1, go to DONE.
- MC_START: mc_start = 1 for one cycle, elem_valid = 0, then MC_WAIT.
- MC_WAIT:
  - Outputs idle until mc_done = 1.
  - In the mc_done cycle, elem_valid = 1 (combinational from mc_done) with the current elem_idx; this is the writeback beat.
  - Then go to MC_START for the next element, or to DONE after the last element.
  - mc_done is ignored in all other states.
- DONE: done = 1 for exactly one cycle, issue_ready = 0, then IDLE.
- Latency, single-cycle op, vlen = N, accepted at cycle 0: beats at cycles 1..N, done at cycle N+1, issue_ready at cycle N+2.
- Latency, MUL/DIV: per element, 1 start cycle plus the wait cycles through mc_done.
- issue_ready is combinational from state; a new issue is never accepted in the DONE cycle.
- elem_idx wraps only by reset or a new issue; it never exceeds eff_len-1.

Optional Feature:
- Macro VSEQ_MC_TIMEOUT_EN.
- With the macro: a counter clears on entry to MC_WAIT. If MC_TIMEOUT cycles pass without mc_done, then:
  - err pulses for 1 cycle;
  - the remaining elements are abandoned;
  - state goes to DONE, so done pulses the next cycle.
- Without the macro: no counter, err tied 0, MC_WAIT waits indefinitely.

Decomposition:
- Package vseq_pkg holds:
  - typedef alu_op_e, with codes ADD..MEM plus ILLEGAL = 3'b110;
  - typedef vseq_state_e;
  - localparams for IDX_W computation.
- Sub-module vseq_elem_counter: loadable index counter with a clear input, an inc input and a last output.

Test Plan:
- ADD (alu_ctrl 000, reg_write 1), vlen = 4 → elem_valid for 4 consecutive cycles with idx 0,1,2,3 and elem_reg_we = 1; done at cycle 5; issue_ready at cycle 6.
- DIV (100), vlen = 2, mc_done returned 3 cycles after each mc_start → 2 mc_start pulses; elem_valid only in the mc_done cycles with idx 0 then 1; single done pulse.
- STR (111, mem_write 1, reg_write 0), vlen = 3 → 3 beats with elem_mem_we = 1 and elem_reg_we = 0.
- Edge cases:
  - vlen = 0 → no beats, done the cycle after accept.
  - vlen = 12 → clamped to 8 beats.
  - alu_ctrl 110 → no beats, done pulse.
- Reset asserted during RUN at idx 2 → next cycle all outputs 0, no done. After release, issue_ready = 1 and a new ADD starts at idx 0.
- Timeout, with VSEQ_MC_TIMEOUT_EN, MC_TIMEOUT = 8: MUL with mc_done held 0 → err pulse after 8 wait cycles, then done. Without the macro, the bench sees stall stay high.
